// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the 19-bit CPU: drives the shared load bus,
// runs the memory request/ack handshake with timeout, and counts executed instructions.
module cpu_sequencer #(
    parameter int OPCODE_W    = 4,
    parameter int IR_LATENCY  = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic                MEM_ACK,
    output logic                MEM_REQ,
    output logic                MEM_WE,
    output logic                ADDR_SEL,
    output logic                LOAD_REG,
    output logic [1:0]          LOAD_SELECT,
    output logic                PC_INC,
    output logic                ALU_EN,
    output logic [OPCODE_W-1:0] ALU_OP,
    output logic                HALTED,
    output logic                BUS_ERR,
    output logic [CNT_W-1:0]    INSTR_COUNT
);

    // Load-bus targets; 0 is reserved for "no load".
    localparam logic [1:0] LOAD_IR  = 2'd1;
    localparam logic [1:0] LOAD_ACC = 2'd2;
    localparam logic [1:0] LOAD_PC  = 2'd3;

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(15);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = (IR_LATENCY > 1) ? $clog2(IR_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q;
    logic [WW-1:0]         wait_q;
    logic [DW-1:0]         dec_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  berr_q;
    logic                  req_st;
    logic                  dec_done;
    logic                  tmo;

    assign req_st   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign dec_done = (state_q == S_DECODE) && (dec_q == DW'(IR_LATENCY - 1));
    // An ack in the final allowed cycle still wins over the timeout.
    assign tmo      = req_st && !MEM_ACK && (wait_q == WW'(MEM_TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            dec_q   <= '0;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= (req_st && !MEM_ACK) ? wait_q + WW'(1) : '0;
            dec_q   <= (state_q == S_DECODE && !dec_done) ? dec_q + DW'(1) : '0;
            if (dec_done) begin
                op_q  <= OPCODE;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (tmo) berr_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        MEM_REQ     = 1'b0;
        MEM_WE      = 1'b0;
        ADDR_SEL    = 1'b0;
        LOAD_REG    = 1'b0;
        LOAD_SELECT = 2'd0;
        PC_INC      = 1'b0;
        ALU_EN      = 1'b0;
        ALU_OP      = '0;
        case (state_q)
            S_IDLE: if (START) state_d = S_FETCH;
            S_FETCH: begin
                MEM_REQ = 1'b1;
                if (MEM_ACK) begin
                    LOAD_REG    = 1'b1;
                    LOAD_SELECT = LOAD_IR;
                    PC_INC      = 1'b1;
                    state_d     = S_DECODE;
                end else if (tmo) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: if (dec_done) state_d = S_EXEC;
            S_EXEC: begin
                if (op_q == OP_NOP) begin
                    state_d = S_FETCH;
                end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    state_d = S_MEM;
                end else if (op_q == OP_JMP) begin
                    LOAD_REG    = 1'b1;
                    LOAD_SELECT = LOAD_PC;
                    ADDR_SEL    = 1'b1;
                    state_d     = S_FETCH;
                end else if (op_q == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    ALU_EN      = 1'b1;
                    ALU_OP      = op_q;
                    LOAD_REG    = 1'b1;
                    LOAD_SELECT = LOAD_ACC;
                    state_d     = S_FETCH;
                end
            end
            S_MEM: begin
                MEM_REQ  = 1'b1;
                ADDR_SEL = 1'b1;
                MEM_WE   = (op_q == OP_STORE);
                if (MEM_ACK) begin
                    if (op_q == OP_LOAD) begin
                        LOAD_REG    = 1'b1;
                        LOAD_SELECT = LOAD_ACC;
                    end
                    state_d = S_FETCH;
                end else if (tmo) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign HALTED      = (state_q == S_HALT);
    assign BUS_ERR     = berr_q;
    assign INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
    localparam int CW = 8;
    localparam logic [1:0] L_IR = 2'd1, L_ACC = 2'd2, L_PC = 2'd3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic          MEM_ACK = 1'b0;
    logic [3:0]    OPCODE = 4'h0;
    logic          MEM_REQ, MEM_WE, ADDR_SEL, LOAD_REG, PC_INC, ALU_EN, HALTED, BUS_ERR;
    logic [1:0]    LOAD_SELECT;
    logic [3:0]    ALU_OP;
    logic [CW-1:0] INSTR_COUNT;

    cpu_sequencer #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE), .MEM_ACK(MEM_ACK),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .ADDR_SEL(ADDR_SEL), .LOAD_REG(LOAD_REG),
        .LOAD_SELECT(LOAD_SELECT), .PC_INC(PC_INC), .ALU_EN(ALU_EN), .ALU_OP(ALU_OP),
        .HALTED(HALTED), .BUS_ERR(BUS_ERR), .INSTR_COUNT(INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          req, we, asel, ld;
        logic [1:0]    lsel;
        logic          inc, alu;
        logic [3:0]    aop;
        logic          halted, berr;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [CW-1:0] m_cnt = '0;
    logic          m_halt = 1'b0;
    logic          m_berr = 1'b0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic obs_t quiet();
        obs_t o;
        o = '0;
        o.halted = m_halt;
        o.berr   = m_berr;
        o.cnt    = m_cnt;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic ack, input logic [3:0] opc, input obs_t e);
        @(posedge CLK);
        #1;
        START   = st;
        MEM_ACK = ack;
        OPCODE  = opc;
        q.push_back(e);
    endtask

    task automatic request(input logic we, input logic asel, input int waits, output bit tmo);
        obs_t e;
        int n;
        n = (waits >= 15) ? 15 : waits;
        for (int i = 0; i < n; i++) begin
            e = quiet(); e.req = 1'b1; e.we = we; e.asel = asel;
            cyc(rb(), 1'b0, r4(), e);
        end
        tmo = (waits >= 15);
        if (tmo) begin
            m_halt = 1'b1;
            m_berr = 1'b1;
        end
    endtask

    task automatic start_cpu();
        cyc(1'b1, rb(), r4(), quiet());
    endtask

    task automatic instr(input logic [3:0] opc, input int fw, input int mw);
        obs_t e;
        bit tmo;
        request(1'b0, 1'b0, fw, tmo);
        if (tmo) return;
        e = quiet(); e.req = 1'b1; e.ld = 1'b1; e.lsel = L_IR; e.inc = 1'b1;
        cyc(rb(), 1'b1, r4(), e);
        cyc(rb(), rb(), r4(), quiet());
        cyc(rb(), rb(), opc, quiet());
        m_cnt = m_cnt + 1'b1;
        e = quiet();
        if (opc == 4'h3) begin
            e.ld = 1'b1; e.lsel = L_PC; e.asel = 1'b1;
        end else if (opc >= 4'h4 && opc <= 4'hE) begin
            e.alu = 1'b1; e.aop = opc; e.ld = 1'b1; e.lsel = L_ACC;
        end
        cyc(rb(), rb(), r4(), e);
        if (opc == 4'hF) m_halt = 1'b1;
        if (opc == 4'h1 || opc == 4'h2) begin
            request(opc == 4'h2, 1'b1, mw, tmo);
            if (!tmo) begin
                e = quiet(); e.req = 1'b1; e.asel = 1'b1; e.we = (opc == 4'h2);
                if (opc == 4'h1) begin
                    e.ld = 1'b1; e.lsel = L_ACC;
                end
                cyc(rb(), 1'b1, r4(), e);
            end
        end
    endtask

    task automatic idle_cycles(input int n, input logic allow_start);
        for (int i = 0; i < n; i++) cyc(allow_start & rb(), rb(), r4(), quiet());
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        START = 1'b0; MEM_ACK = 1'b0;
        m_cnt = '0; m_halt = 1'b0; m_berr = 1'b0;
        q.push_back(quiet());
        #1 RST_N = 1'b0;
        #1;
        chk("reset_mem_req", MEM_REQ, 0);
        chk("reset_instr_count", INSTR_COUNT, 0);
        chk("reset_halted", HALTED, 0);
        chk("reset_bus_err", BUS_ERR, 0);
        cyc(1'b0, 1'b0, r4(), quiet());
        cyc(1'b0, 1'b0, r4(), quiet());
        #5 RST_N = 1'b1;
    endtask

    always @(negedge CLK) begin
        obs_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {MEM_REQ, MEM_WE, ADDR_SEL, LOAD_REG, LOAD_SELECT, PC_INC, ALU_EN,
                 (e.alu ? ALU_OP : 4'h0), HALTED, BUS_ERR, INSTR_COUNT};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL bus_cycle @%0t: got req%b we%b asel%b ld%b sel%0d inc%b alu%b op%h hlt%b err%b cnt%0d, want req%b we%b asel%b ld%b sel%0d inc%b alu%b op%h hlt%b err%b cnt%0d",
                         $time, a.req, a.we, a.asel, a.ld, a.lsel, a.inc, a.alu, a.aop, a.halted, a.berr, a.cnt,
                         e.req, e.we, e.asel, e.ld, e.lsel, e.inc, e.alu, e.aop, e.halted, e.berr, e.cnt);
            end
        end
    end

    initial begin
        bit tmo;
        #12 RST_N = 1'b1;
        idle_cycles(3, 1'b0);

        start_cpu();
        instr(4'h5, 0, 0);
        request(1'b0, 1'b0, 3, tmo);
        do_reset();
        idle_cycles(2, 1'b0);

        start_cpu();
        instr(4'h1, 1, 3);
        instr(4'h2, 0, 0);
        instr(4'h3, 2, 0);
        instr(4'h0, 0, 0);
        instr(4'hE, 0, 0);
        instr(4'h2, 0, 14);
        instr(4'h1, 14, 0);

        instr(4'h0, 15, 0);
        idle_cycles(6, 1'b1);
        chk("fetch_timeout_bus_err", BUS_ERR, 1);
        chk("fetch_timeout_halted", HALTED, 1);
        chk("fetch_timeout_mem_req", MEM_REQ, 0);
        do_reset();

        start_cpu();
        instr(4'h2, 0, 15);
        idle_cycles(4, 1'b1);
        chk("mem_timeout_bus_err", BUS_ERR, 1);
        chk("mem_timeout_halted", HALTED, 1);
        chk("mem_timeout_mem_req", MEM_REQ, 0);
        do_reset();

        start_cpu();
        while (m_cnt != {CW{1'b1}})
            instr(4'($urandom_range(0, 14)), $urandom_range(0, 4), $urandom_range(0, 4));
        instr(4'h0, 0, 0);
        instr(4'h7, 1, 0);
        instr(4'hF, 0, 0);
        idle_cycles(5, 1'b1);
        chk("halt_op_halted", HALTED, 1);

        @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
